input_conditioner: RTL and testbench

- Multi-channel successor to the board button-parsing path.
- Per channel: synchronise, symmetrically debounce, then derive press/release/long-press pulses and a toggle state.
- A run-time mode per channel selects which of these drives out[i].
- An integrated reset generator issues a stretched reset pulse from a designated channel, so the top level no longer gates reset with ad-hoc logic.

---
 rtl/input_conditioner.sv | 140 ++++++++++++++
 tb/tb_input_conditioner.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/input_conditioner.sv
// Multi-channel input conditioner: sync, debounce, edge/long-press pulses,
// toggle state, per-channel output select and a stretched reset generator.
module input_conditioner #(
  parameter int WIDTH          = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int SAMPLE_CNT_MAX = 25000,
  parameter int PULSE_CNT_MAX  = 200,
  parameter int LONG_CNT_MAX   = 2000,
  parameter int RST_CH         = 0,
  parameter int RST_STRETCH    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   in,
  input  logic [2*WIDTH-1:0] mode,
  input  logic               rst_en,
  output logic [WIDTH-1:0]   level,
  output logic [WIDTH-1:0]   press,
  output logic [WIDTH-1:0]   release_pulse,
  output logic [WIDTH-1:0]   long_press,
  output logic [WIDTH-1:0]   toggle,
  output logic [WIDTH-1:0]   out,
  output logic               rst_out
);

  localparam int SW = $clog2(SAMPLE_CNT_MAX + 1);
  localparam int DW = $clog2(PULSE_CNT_MAX + 1);
  localparam int HW = $clog2(LONG_CNT_MAX + 1);
  localparam int RW = $clog2(RST_STRETCH + 1);

  localparam logic [SW-1:0] S_LAST = SW'(SAMPLE_CNT_MAX - 1);
  localparam logic [DW-1:0] D_LAST = DW'(PULSE_CNT_MAX - 1);
  localparam logic [HW-1:0] H_MAX  = HW'(LONG_CNT_MAX);
  localparam logic [HW-1:0] H_LAST = HW'(LONG_CNT_MAX - 1);
  localparam logic [RW-1:0] R_LOAD = RW'(RST_STRETCH - 1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync;
  logic [SW-1:0]    scnt;
  logic             tick;
  logic [RW-1:0]    rcnt;

  assign sync = sync_q[SYNC_STAGES-1];
  assign tick = (scnt == S_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++)
        sync_q[s] <= '0;
    end else begin
      sync_q[0] <= in;
      for (int s = 1; s < SYNC_STAGES; s++)
        sync_q[s] <= sync_q[s-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst)       scnt <= '0;
    else if (tick) scnt <= '0;
    else           scnt <= scnt + 1'b1;
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    logic [DW-1:0] dcnt;
    logic [HW-1:0] hcnt;
    logic          lvl_q;
    logic          prs_q;
    logic          rel_q;
    logic          lng_q;
    logic          tgl_q;
    logic          differ;
    logic          flip;
    logic          out_c;

    assign differ = (sync[i] != lvl_q);
    assign flip   = tick && differ && (dcnt == D_LAST);

    always_ff @(posedge clk) begin
      if (rst) begin
        dcnt  <= '0;
        hcnt  <= '0;
        lvl_q <= 1'b0;
        prs_q <= 1'b0;
        rel_q <= 1'b0;
        lng_q <= 1'b0;
        tgl_q <= 1'b0;
      end else begin
        prs_q <= flip & sync[i];
        rel_q <= flip & ~sync[i];
        lng_q <= 1'b0;
        if (tick) begin
          if (!differ)    dcnt <= '0;
          else if (flip) begin
            dcnt  <= '0;
            lvl_q <= sync[i];
          end else        dcnt <= dcnt + 1'b1;
        end
        // hold count is based on the level before this edge
        if (!lvl_q) hcnt <= '0;
        else if (tick && hcnt != H_MAX) begin
          hcnt  <= hcnt + 1'b1;
          lng_q <= (hcnt == H_LAST);
        end
        if (flip && sync[i]) tgl_q <= ~tgl_q;
      end
    end

    always_comb begin
      out_c = lvl_q;
      unique case (mode[2*i +: 2])
        2'b00: out_c = lvl_q;
        2'b01: out_c = prs_q;
        2'b10: out_c = tgl_q;
        2'b11: out_c = lng_q;
      endcase
    end

    assign level[i]         = lvl_q;
    assign press[i]         = prs_q;
    assign release_pulse[i] = rel_q;
    assign long_press[i]    = lng_q;
    assign toggle[i]        = tgl_q;
    assign out[i]           = out_c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rst_out <= 1'b0;
      rcnt    <= '0;
    end else if (rst_en && press[RST_CH]) begin
      rst_out <= 1'b1;
      rcnt    <= R_LOAD;
    end else if (rcnt != '0) begin
      rcnt <= rcnt - 1'b1;
    end else begin
      rst_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Randomised bench for input_conditioner against a behavioural
// per-cycle model built from sample counts and hold durations.
module tb_input_conditioner;

  localparam int W    = 4;
  localparam int SYN  = 2;
  localparam int SMAX = 4;
  localparam int PMAX = 3;
  localparam int LMAX = 8;
  localparam int RCH  = 0;
  localparam int STR  = 5;
  localparam int NCYC = 8000;

  logic           clk = 1'b0;
  logic           rst;
  logic [W-1:0]   in;
  logic [2*W-1:0] mode;
  logic           rst_en;
  logic [W-1:0]   level;
  logic [W-1:0]   press;
  logic [W-1:0]   release_pulse;
  logic [W-1:0]   long_press;
  logic [W-1:0]   toggle;
  logic [W-1:0]   out;
  logic           rst_out;

  always #5 clk = ~clk;

  input_conditioner #(
    .WIDTH(W),
    .SYNC_STAGES(SYN),
    .SAMPLE_CNT_MAX(SMAX),
    .PULSE_CNT_MAX(PMAX),
    .LONG_CNT_MAX(LMAX),
    .RST_CH(RCH),
    .RST_STRETCH(STR)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in(in),
    .mode(mode),
    .rst_en(rst_en),
    .level(level),
    .press(press),
    .release_pulse(release_pulse),
    .long_press(long_press),
    .toggle(toggle),
    .out(out),
    .rst_out(rst_out)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      if (n_err <= 30)
        $display("FAIL %s got=%h exp=%h t=%0t",
                 tag, got, exp, $time);
    end
  endtask

  // reference state
  logic [W-1:0] hist[$];
  logic [W-1:0] m_level, m_press, m_rel;
  logic [W-1:0] m_long, m_toggle;
  logic         m_rst_out;
  int           run[W];
  int           hold[W];
  int           ncyc;
  int           rem;

  task automatic model_reset();
    hist = {};
    repeat (SYN) hist.push_back('0);
    m_level   = '0;
    m_press   = '0;
    m_rel     = '0;
    m_long    = '0;
    m_toggle  = '0;
    m_rst_out = 1'b0;
    ncyc      = 0;
    rem       = 0;
    for (int i = 0; i < W; i++) begin
      run[i]  = 0;
      hold[i] = 0;
    end
  endtask

  task automatic model_step();
    logic [W-1:0] samp;
    logic [W-1:0] lvl_pre;
    bit           tick;
    if (rst) begin
      model_reset();
      return;
    end
    samp = hist.pop_front();
    hist.push_back(in);
    ncyc++;
    tick = (ncyc % SMAX) == 0;
    if (m_press[RCH] && rst_en) rem = STR;
    m_rst_out = (rem > 0);
    if (rem > 0) rem--;
    lvl_pre = m_level;
    m_press = '0;
    m_rel   = '0;
    m_long  = '0;
    for (int i = 0; i < W; i++) begin
      if (!lvl_pre[i]) hold[i] = 0;
      else if (tick) begin
        hold[i]++;
        m_long[i] = (hold[i] == LMAX);
      end
      if (tick) begin
        if (samp[i] == lvl_pre[i]) run[i] = 0;
        else begin
          run[i]++;
          if (run[i] == PMAX) begin
            run[i]     = 0;
            m_level[i] = samp[i];
            m_press[i] = samp[i];
            m_rel[i]   = !samp[i];
            if (samp[i]) m_toggle[i] = !m_toggle[i];
          end
        end
      end
    end
  endtask

  function automatic logic [W-1:0] model_out();
    logic [W-1:0] o;
    o = '0;
    for (int i = 0; i < W; i++) begin
      case (mode[2*i +: 2])
        2'b00:   o[i] = m_level[i];
        2'b01:   o[i] = m_press[i];
        2'b10:   o[i] = m_toggle[i];
        default: o[i] = m_long[i];
      endcase
    end
    return o;
  endfunction

  int dur[W];

  initial begin
    rst    = 1'b1;
    in     = '0;
    mode   = '0;
    rst_en = 1'b0;
    for (int i = 0; i < W; i++) dur[i] = 0;
    model_reset();
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      check("level",   level,         m_level);
      check("press",   press,         m_press);
      check("release", release_pulse, m_rel);
      check("long",    long_press,    m_long);
      check("toggle",  toggle,        m_toggle);
      check("out",     out,           model_out());
      check("rst_out", rst_out,       m_rst_out);
      if (cyc < 3) rst = 1'b1;
      else rst = ($urandom_range(0, 399) == 0);
      for (int i = 0; i < W; i++) begin
        if (dur[i] == 0) begin
          if ($urandom_range(0, 3) != 0) in[i] = ~in[i];
          if ($urandom_range(0, 2) == 0)
            dur[i] = $urandom_range(1, 10);
          else
            dur[i] = $urandom_range(15, 80);
        end else begin
          dur[i]--;
        end
      end
      if (cyc % 37 == 0) mode = 8'($urandom);
      if (cyc % 101 == 0) rst_en = 1'($urandom_range(0, 1));
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
